// File: rtl/dl_replay_ctrl.sv
// rtl/dl_replay_ctrl.sv - TX data link sequencing and replay controller (optional stats: DL_REPLAY_STATS_EN)
module dl_replay_ctrl #(
    parameter int         REPLAY_TIMEOUT  = 711,
    parameter int         MAX_OUTSTANDING = 2048,
    parameter logic [7:0] ACK_TYPE        = 8'h00,
    parameter logic [7:0] NAK_TYPE        = 8'h10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_tlp_sent,
    output logic [11:0] tx_seq_num,
    output logic        tlp_accept_en,
    input  logic [31:0] dllp,
    input  logic        dllp_valid,
    output logic        purge_valid,
    output logic [11:0] purge_seq,
    output logic        replay_req,
    output logic [11:0] replay_start_seq,
    output logic [11:0] replay_len,
    input  logic        replay_ack,
    input  logic        replay_done,
    output logic        retrain_req,
    output logic        dllp_err,
    output logic [11:0] outstanding
`ifdef DL_REPLAY_STATS_EN
    ,
    output logic [15:0] replay_count,
    output logic [15:0] nak_count
`endif
);

    localparam int              TW         = $clog2(REPLAY_TIMEOUT + 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(REPLAY_TIMEOUT - 1);
    localparam logic [12:0]     MAX_OUT    = 13'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, REPLAY, WAIT_DONE} state_t;

    state_t        state, state_nxt;
    logic [11:0]   next_seq, acked_seq;
    logic [TW-1:0] timer, timer_nxt;
    logic [1:0]    replay_num;

    logic [11:0]   ack_s, ack_d, acked_nxt, next_seq_nxt, outst_nxt;
    logic          is_ack, is_nak, ack_nak, win_ok, dl_ok, progress;
    logic          tx_take, replay_enter, replay_go;
    logic [1:0]    rn_base;

    // Upper DLLP bits carry fields this block does not use
    logic unused_dllp_bits;
    assign unused_dllp_bits = ^dllp[23:12];

    assign tx_seq_num    = next_seq;
    assign outstanding   = next_seq - 12'd1 - acked_seq;
    assign tlp_accept_en = (state == IDLE) && ({1'b0, outstanding} < MAX_OUT);
    assign replay_req    = (state == REPLAY);

    // ACK/NAK decode, window check and post-update sequence values
    always_comb begin
        ack_s        = dllp[11:0];
        ack_d        = ack_s - acked_seq;
        is_ack       = dllp_valid && (dllp[31:24] == ACK_TYPE);
        is_nak       = dllp_valid && (dllp[31:24] == NAK_TYPE);
        ack_nak      = is_ack || is_nak;
        win_ok       = (ack_d <= outstanding);
        dl_ok        = ack_nak && win_ok;
        progress     = dl_ok && (ack_d != 12'd0);
        tx_take      = tx_tlp_sent && tlp_accept_en;
        acked_nxt    = progress ? ack_s : acked_seq;
        next_seq_nxt = next_seq + {11'd0, tx_take};
        outst_nxt    = next_seq_nxt - 12'd1 - acked_nxt;
        rn_base      = progress ? 2'd0 : replay_num;
    end

    // Next-state, replay scheduling and replay timer
    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        replay_enter = 1'b0;
        replay_go    = 1'b0;
        case (state)
            IDLE: begin
                if (is_nak && dl_ok) begin
                    replay_enter = 1'b1;
                end else if ((timer == TIMER_LAST) && !progress) begin
                    replay_enter = 1'b1;
                end
                if (replay_enter || progress || (outstanding == 12'd0)) begin
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
                // An empty replay window needs no retry buffer work
                if (replay_enter && (outst_nxt != 12'd0)) begin
                    replay_go = 1'b1;
                    state_nxt = REPLAY;
                end
            end
            REPLAY: begin
                if (progress) timer_nxt = '0;
                if (replay_ack) begin
                    if (replay_done) begin
                        state_nxt = IDLE;
                        timer_nxt = '0;
                    end else begin
                        state_nxt = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (progress) timer_nxt = '0;
                if (replay_done) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // State, sequence tracking and pulse outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            next_seq         <= 12'd0;
            acked_seq        <= 12'hFFF;
            timer            <= '0;
            replay_num       <= 2'd0;
            purge_valid      <= 1'b0;
            purge_seq        <= 12'd0;
            dllp_err         <= 1'b0;
            retrain_req      <= 1'b0;
            replay_start_seq <= 12'd0;
            replay_len       <= 12'd0;
        end else begin
            state       <= state_nxt;
            next_seq    <= next_seq_nxt;
            acked_seq   <= acked_nxt;
            timer       <= timer_nxt;
            purge_valid <= progress;
            dllp_err    <= ack_nak && !win_ok;
            retrain_req <= replay_enter && (rn_base == 2'd3);
            replay_num  <= replay_enter ? rn_base + 2'd1 : rn_base;
            if (progress) purge_seq <= ack_s;
            if (replay_enter) begin
                replay_start_seq <= acked_nxt + 12'd1;
                replay_len       <= outst_nxt;
            end
        end
    end

`ifdef DL_REPLAY_STATS_EN
    // Saturating replay and NAK statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            replay_count <= 16'd0;
            nak_count    <= 16'd0;
        end else begin
            if (replay_go && (replay_count != 16'hFFFF)) replay_count <= replay_count + 16'd1;
            if (is_nak && dl_ok && (nak_count != 16'hFFFF)) nak_count <= nak_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dl_replay_ctrl.sv
// tb/tb_dl_replay_ctrl.sv - directed self-checking bench for dl_replay_ctrl
module tb_dl_replay_ctrl;

    localparam logic [7:0] ACK = 8'h00;
    localparam logic [7:0] NAK = 8'h10;

    logic        clk = 1'b0;
    logic        reset, tx_tlp_sent, dllp_valid, replay_ack, replay_done;
    logic [31:0] dllp;
    logic [11:0] tx_seq_num, purge_seq, replay_start_seq, replay_len, outstanding;
    logic        tlp_accept_en, purge_valid, replay_req, retrain_req, dllp_err;
`ifdef DL_REPLAY_STATS_EN
    logic [15:0] replay_count, nak_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dl_replay_ctrl dut (
        .clk(clk), .reset(reset), .tx_tlp_sent(tx_tlp_sent), .tx_seq_num(tx_seq_num),
        .tlp_accept_en(tlp_accept_en), .dllp(dllp), .dllp_valid(dllp_valid),
        .purge_valid(purge_valid), .purge_seq(purge_seq), .replay_req(replay_req),
        .replay_start_seq(replay_start_seq), .replay_len(replay_len),
        .replay_ack(replay_ack), .replay_done(replay_done), .retrain_req(retrain_req),
        .dllp_err(dllp_err), .outstanding(outstanding)
`ifdef DL_REPLAY_STATS_EN
        , .replay_count(replay_count), .nak_count(nak_count)
`endif
    );

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; tx_tlp_sent = 1'b0; dllp_valid = 1'b0; dllp = 32'd0;
        replay_ack = 1'b0; replay_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_n(input int n);
        repeat (n) begin
            @(negedge clk);
            tx_tlp_sent = 1'b1;
        end
        @(negedge clk);
        tx_tlp_sent = 1'b0;
    endtask

    task automatic send_dllp(input logic [7:0] t, input logic [11:0] s);
        @(negedge clk);
        dllp = {t, 12'h000, s};
        dllp_valid = 1'b1;
        @(negedge clk);
        dllp_valid = 1'b0;
    endtask

    task automatic wait_replay(output int k);
        k = 0;
        while (!replay_req && k < 1000) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic finish_replay();
        replay_ack = 1'b1;
        @(negedge clk);
        replay_ack = 1'b0;
        replay_done = 1'b1;
        @(negedge clk);
        replay_done = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++; if (tx_seq_num !== 12'd0) begin n_fail++; $display("FAIL rst_tx_seq: got %0d want 0", tx_seq_num); end
        n_tests++; if (outstanding !== 12'd0) begin n_fail++; $display("FAIL rst_outstanding: got %0d want 0", outstanding); end
        n_tests++; if (tlp_accept_en !== 1'b1) begin n_fail++; $display("FAIL rst_accept: got %b want 1", tlp_accept_en); end
        n_tests++; if ({purge_valid, replay_req, retrain_req, dllp_err} !== 4'b0000) begin n_fail++; $display("FAIL rst_pulses: got %b want 0000", {purge_valid, replay_req, retrain_req, dllp_err}); end
        n_tests++; if ({replay_start_seq, replay_len, purge_seq} !== 36'd0) begin n_fail++; $display("FAIL rst_regs: got %h want 0", {replay_start_seq, replay_len, purge_seq}); end
    endtask

    task automatic test_ack();
        apply_reset();
        send_n(5);
        n_tests++; if (tx_seq_num !== 12'd5) begin n_fail++; $display("FAIL ack_tx_seq: got %0d want 5", tx_seq_num); end
        n_tests++; if (outstanding !== 12'd5) begin n_fail++; $display("FAIL ack_outst5: got %0d want 5", outstanding); end
        send_dllp(ACK, 12'd2);
        n_tests++; if (purge_valid !== 1'b1) begin n_fail++; $display("FAIL ack_purge_valid: got %b want 1", purge_valid); end
        n_tests++; if (purge_seq !== 12'd2) begin n_fail++; $display("FAIL ack_purge_seq: got %0d want 2", purge_seq); end
        n_tests++; if (outstanding !== 12'd2) begin n_fail++; $display("FAIL ack_outst2: got %0d want 2", outstanding); end
        @(negedge clk);
        n_tests++; if (purge_valid !== 1'b0) begin n_fail++; $display("FAIL ack_purge_pulse: got %b want 0", purge_valid); end
    endtask

    task automatic test_nak();
        apply_reset();
        send_n(5);
        send_dllp(NAK, 12'd1);
        n_tests++; if ({purge_valid, purge_seq} !== {1'b1, 12'd1}) begin n_fail++; $display("FAIL nak_purge: got %b/%0d want 1/1", purge_valid, purge_seq); end
        n_tests++; if (replay_req !== 1'b1) begin n_fail++; $display("FAIL nak_replay_req: got %b want 1", replay_req); end
        n_tests++; if (replay_start_seq !== 12'd2) begin n_fail++; $display("FAIL nak_start: got %0d want 2", replay_start_seq); end
        n_tests++; if (replay_len !== 12'd3) begin n_fail++; $display("FAIL nak_len: got %0d want 3", replay_len); end
        n_tests++; if (tlp_accept_en !== 1'b0) begin n_fail++; $display("FAIL nak_accept: got %b want 0", tlp_accept_en); end
        replay_ack = 1'b1;
        @(negedge clk);
        replay_ack = 1'b0;
        n_tests++; if ({replay_req, tlp_accept_en} !== 2'b00) begin n_fail++; $display("FAIL nak_wait_done: got %b want 00", {replay_req, tlp_accept_en}); end
        replay_done = 1'b1;
        @(negedge clk);
        replay_done = 1'b0;
        n_tests++; if (tlp_accept_en !== 1'b1) begin n_fail++; $display("FAIL nak_idle_accept: got %b want 1", tlp_accept_en); end
    endtask

    task automatic test_timeout();
        int  k;
        logic exp_rt;
        apply_reset();
        send_n(1);
        for (int i = 1; i <= 4; i++) begin
            exp_rt = (i == 4);
            wait_replay(k);
            n_tests++; if (k !== 711) begin n_fail++; $display("FAIL to_latency%0d: got %0d want 711", i, k); end
            n_tests++; if (retrain_req !== exp_rt) begin n_fail++; $display("FAIL to_retrain%0d: got %b want %b", i, retrain_req, exp_rt); end
            if (i == 1) begin
                n_tests++; if ({replay_start_seq, replay_len} !== {12'd0, 12'd1}) begin n_fail++; $display("FAIL to_window: got %0d/%0d want 0/1", replay_start_seq, replay_len); end
            end
            finish_replay();
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int b = 0; b < 9; b++) begin
            send_n((b < 8) ? 500 : 94);
            send_dllp(ACK, tx_seq_num - 12'd1);
        end
        n_tests++; if ({tx_seq_num, outstanding} !== {12'd4094, 12'd0}) begin n_fail++; $display("FAIL wrap_pre: got %0d/%0d want 4094/0", tx_seq_num, outstanding); end
        send_n(4);
        n_tests++; if ({tx_seq_num, outstanding} !== {12'd2, 12'd4}) begin n_fail++; $display("FAIL wrap_sent: got %0d/%0d want 2/4", tx_seq_num, outstanding); end
        send_dllp(ACK, 12'd0);
        n_tests++; if ({purge_valid, purge_seq} !== {1'b1, 12'd0}) begin n_fail++; $display("FAIL wrap_purge: got %b/%0d want 1/0", purge_valid, purge_seq); end
        n_tests++; if (outstanding !== 12'd1) begin n_fail++; $display("FAIL wrap_outst: got %0d want 1", outstanding); end
        send_dllp(ACK, 12'd4090);
        n_tests++; if ({dllp_err, purge_valid} !== 2'b10) begin n_fail++; $display("FAIL wrap_err: got %b want 10", {dllp_err, purge_valid}); end
        n_tests++; if ({tx_seq_num, outstanding, replay_req} !== {12'd2, 12'd1, 1'b0}) begin n_fail++; $display("FAIL wrap_unchanged: got %0d/%0d/%b want 2/1/0", tx_seq_num, outstanding, replay_req); end
        send_dllp(8'h20, 12'd4090);
        n_tests++; if (dllp_err !== 1'b0) begin n_fail++; $display("FAIL wrap_other_type: got %b want 0", dllp_err); end
    endtask

    task automatic test_max_outstanding();
        int sent = 0;
        int guard = 0;
        apply_reset();
        while (sent < 2048 && guard < 20000) begin
            guard++;
            @(negedge clk);
            tx_tlp_sent = 1'b0; replay_ack = 1'b0; replay_done = 1'b0;
            if (replay_req) begin
                replay_ack = 1'b1; replay_done = 1'b1;
            end else if (tlp_accept_en) begin
                tx_tlp_sent = 1'b1; sent++;
            end
        end
        @(negedge clk);
        tx_tlp_sent = 1'b0; replay_ack = 1'b0; replay_done = 1'b0;
        if (replay_req) finish_replay();
        n_tests++; if (outstanding !== 12'd2048) begin n_fail++; $display("FAIL max_fill: got %0d want 2048", outstanding); end
        send_dllp(NAK, 12'hFFF);
        n_tests++; if ({replay_req, replay_len} !== {1'b1, 12'd2048}) begin n_fail++; $display("FAIL max_nak_d0: got %b/%0d want 1/2048", replay_req, replay_len); end
        finish_replay();
        n_tests++; if (tlp_accept_en !== 1'b0) begin n_fail++; $display("FAIL max_accept: got %b want 0", tlp_accept_en); end
        send_n(1);
        n_tests++; if (tx_seq_num !== 12'd2048) begin n_fail++; $display("FAIL max_ignore_tx: got %0d want 2048", tx_seq_num); end
        send_dllp(ACK, 12'd0);
        n_tests++; if ({tlp_accept_en, outstanding} !== {1'b1, 12'd2047}) begin n_fail++; $display("FAIL max_reopen: got %b/%0d want 1/2047", tlp_accept_en, outstanding); end
    endtask

    task automatic test_ack_vs_timeout();
        int k;
        apply_reset();
        send_n(5);
        repeat (705) @(negedge clk);
        send_dllp(ACK, 12'd3);
        n_tests++; if ({purge_valid, purge_seq} !== {1'b1, 12'd3}) begin n_fail++; $display("FAIL race_purge: got %b/%0d want 1/3", purge_valid, purge_seq); end
        n_tests++; if ({replay_req, outstanding} !== {1'b0, 12'd1}) begin n_fail++; $display("FAIL race_no_replay: got %b/%0d want 0/1", replay_req, outstanding); end
        wait_replay(k);
        n_tests++; if (k !== 711) begin n_fail++; $display("FAIL race_timer_cleared: got %0d want 711", k); end
        n_tests++; if ({replay_start_seq, replay_len} !== {12'd4, 12'd1}) begin n_fail++; $display("FAIL race_window: got %0d/%0d want 4/1", replay_start_seq, replay_len); end
        replay_ack = 1'b1;
        @(negedge clk);
        replay_ack = 1'b0;
        n_tests++; if ({replay_req, tlp_accept_en} !== 2'b00) begin n_fail++; $display("FAIL race_wait_done: got %b want 00", {replay_req, tlp_accept_en}); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++; if ({tx_seq_num, outstanding, tlp_accept_en} !== {12'd0, 12'd0, 1'b1}) begin n_fail++; $display("FAIL midrst_seq: got %0d/%0d/%b want 0/0/1", tx_seq_num, outstanding, tlp_accept_en); end
        n_tests++; if ({replay_req, replay_start_seq, replay_len, purge_valid, retrain_req, dllp_err} !== 28'd0) begin n_fail++; $display("FAIL midrst_replay: got %h want 0", {replay_req, replay_start_seq, replay_len, purge_valid, retrain_req, dllp_err}); end
    endtask

    initial begin
        reset = 1'b1; tx_tlp_sent = 1'b0; dllp_valid = 1'b0; dllp = 32'd0;
        replay_ack = 1'b0; replay_done = 1'b0;
        test_reset();
        test_ack();
        test_nak();
        test_timeout();
        test_wrap();
        test_max_outstanding();
        test_ack_vs_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
